dmem_lsu: RTL

- Parametrised load/store unit between the execute stage and a synchronous data SRAM.
- Accepts one request per handshake and drives the SRAM with word address, byte enables and lane-replicated write data.
- Waits a configurable read latency, then returns a registered, sign/zero-extended load result or a store acknowledge.
- Detects misaligned and illegal-funct3 accesses and returns them as errors without touching memory. Provides the pipeline stall signal.

---
 rtl/dmem_lsu_pkg.sv | 15 +
 rtl/dmem_align.sv | 38 +++
 rtl/dmem_lsu.sv | 87 ++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: funct3 codes, LSU state encoding and response cause values
package dmem_lsu_pkg;
    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;
    localparam logic [1:0] CAUSE_OK       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} lsu_state_t;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: access checking, store lane steering and load lane extraction
module dmem_align
    import dmem_lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        err,
    output logic [1:0]  cause,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    logic illegal, misalign;
    logic [7:0] b;
    logic [15:0] h;
    always_comb begin
        illegal   = we ? !(funct3 == FUNC3_SB || funct3 == FUNC3_SH || funct3 == FUNC3_SW)
                       : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misalign  = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
        err       = illegal || misalign;
        cause     = illegal ? CAUSE_ILLEGAL : misalign ? CAUSE_MISALIGN : CAUSE_OK;
        be        = funct3[1:0] == 2'b00 ? 4'b0001 << off :
                    funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata_rep = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                    funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        b         = rdata[{ld_off, 3'b000} +: 8];
        h         = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_data   = ld_funct3 == FUNC3_LB  ? {{24{b[7]}}, b} :
                    ld_funct3 == FUNC3_LH  ? {{16{h[15]}}, h} :
                    ld_funct3 == FUNC3_LBU ? {24'h0, b} :
                    ld_funct3 == FUNC3_LHU ? {16'h0, h} : rdata;
    end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a synchronous data SRAM with a fixed read latency
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_cause,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    lsu_state_t state, nstate;
    logic [1:0] cnt, off_q;
    logic [2:0] f3_q;
    logic [3:0] be;
    logic [31:0] ld_data;
    logic err, accept, unused_addr;
    logic [1:0] cause;

    dmem_align u_align (
        .we(req_we), .funct3(req_funct3), .off(req_addr[1:0]), .wdata(req_wdata),
        .be(be), .wdata_rep(mem_wdata), .err(err), .cause(cause),
        .ld_funct3(f3_q), .ld_off(off_q), .rdata(mem_rdata), .ld_data(ld_data)
    );

    assign unused_addr = ^req_addr[31:ADDR_W];
    assign req_ready   = state == ST_IDLE || state == ST_RESP;
    assign accept      = req_valid && req_ready;
    assign stall       = req_valid && !req_ready;
    assign mem_en      = accept && !err;
    assign mem_we      = (mem_en && req_we) ? be : 4'b0000;
    assign mem_addr    = req_addr[ADDR_W-1:2];
    assign resp_valid  = state == ST_RESP;

    always_comb begin
        nstate = state;
        if (accept) nstate = (req_we || err) ? ST_RESP : ST_WAIT;
        else if (state == ST_RESP) nstate = ST_IDLE;
        else if (state == ST_WAIT && cnt == 2'd0) nstate = ST_RESP;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            cnt        <= 2'd0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            resp_cause <= CAUSE_OK;
        end else begin
            state <= nstate;
            if (accept && !req_we && !err) begin
                cnt   <= 2'(MEM_LAT - 1);
                f3_q  <= req_funct3;
                off_q <= req_addr[1:0];
            end else if (state == ST_WAIT && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            // stores and rejected accesses answer immediately with zero data
            if (accept && (req_we || err)) begin
                resp_rdata <= 32'h0;
                resp_err   <= err;
                resp_cause <= cause;
            end else if (state == ST_WAIT && cnt == 2'd0) begin
                resp_rdata <= ld_data;
                resp_err   <= 1'b0;
                resp_cause <= CAUSE_OK;
            end
        end
    end
endmodule
